// File: rtl/linear_stream_engine_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// linear_stream_engine_pkg - FSM encodings and requant helpers.     Rev 1.0
// ----------------------------------------------------------------------------
package linear_stream_engine_pkg;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
  localparam logic [ST_W-1:0] ST_MAC  = 3'd2;
  localparam logic [ST_W-1:0] ST_FIN  = 3'd3;
  localparam logic [ST_W-1:0] ST_OUT  = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE = 3'd5;

  // Wide working width for requant so bias add and rounding never wrap.
  localparam int unsigned REQ_W = 64;

  function automatic int unsigned acc_w_min(input int unsigned in_dim,
                                            input int unsigned data_w);
    return 2 * data_w + $clog2(in_dim) + 1;
  endfunction

  function automatic logic signed [REQ_W-1:0] requant(
    input logic signed [REQ_W-1:0] v_in,
    input logic [4:0]              shift,
    input logic                    relu,
    input int unsigned             data_w
  );
    logic signed [REQ_W-1:0] v;
    logic signed [REQ_W-1:0] max_v;
    logic signed [REQ_W-1:0] min_v;
    v = v_in;
    if (shift != 5'd0) begin
      v = v + (REQ_W'(1) << (shift - 5'd1));
    end
    v = v >>> shift;
    if (relu && (v < 0)) begin
      v = '0;
    end
    max_v = (REQ_W'(1) << (data_w - 1)) - REQ_W'(1);
    min_v = -max_v - REQ_W'(1);
    if (v > max_v) begin
      v = max_v;
    end else if (v < min_v) begin
      v = min_v;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/linear_stream_engine_mac_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// linear_stream_engine_mac_lane - one output column: MAC then requant.  Rev 1.0
// ----------------------------------------------------------------------------
module linear_stream_engine_mac_lane
  import linear_stream_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              mac_en_i,
  input  logic              fin_en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] bias_i,
  input  logic [4:0]        shift_i,
  input  logic              relu_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [REQ_W-1:0]  biased;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [DATA_W-1:0]        y_q, y_d;

  assign prod   = PROD_W'($signed(x_i)) * PROD_W'($signed(w_i));
  assign biased = REQ_W'($signed(acc_q)) + REQ_W'($signed(bias_i));

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_comb begin
    y_d = y_q;
    if (fin_en_i) begin
      y_d = DATA_W'(requant(biased, shift_i, relu_i, DATA_W));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/linear_stream_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// linear_stream_engine - time-multiplexed requantising linear layer.   Rev 1.0
// ----------------------------------------------------------------------------
module linear_stream_engine
  import linear_stream_engine_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int IN_DIM  = 16,
  parameter int OUT_DIM = 16,
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int ACC_W   = 2 * DATA_W + $clog2(IN_DIM) + 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_i,
  output logic                               busy_o,
  output logic                               done_o,
  input  logic [4:0]                         cfg_shift_i,
  input  logic                               cfg_relu_i,
  input  logic [ROWS*IN_DIM*DATA_W-1:0]      x_in_i,
  input  logic [IN_DIM*OUT_DIM*DATA_W-1:0]   w_in_i,
  input  logic [OUT_DIM*DATA_W-1:0]          bias_in_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [LANES*DATA_W-1:0]            out_data_o,
  output logic [$clog2(ROWS)-1:0]            out_row_o,
  output logic [$clog2(OUT_DIM)-1:0]         out_col_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(OUT_DIM);
  localparam int K_W   = $clog2(IN_DIM);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_DIM - LANES);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(LANES);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(IN_DIM - 1);

  if (ACC_W < int'(acc_w_min(IN_DIM, DATA_W))) begin : g_bad_acc_w
    $error("linear_stream_engine: ACC_W too small for IN_DIM/DATA_W");
  end
  if (ACC_W >= int'(REQ_W)) begin : g_bad_acc_wide
    $error("linear_stream_engine: ACC_W exceeds requant working width");
  end
  if ((OUT_DIM % LANES) != 0) begin : g_bad_lanes
    $error("linear_stream_engine: OUT_DIM must be a multiple of LANES");
  end

  logic [DATA_W-1:0] x_arr [ROWS][IN_DIM];
  logic [DATA_W-1:0] w_arr [IN_DIM][OUT_DIM];
  logic [DATA_W-1:0] b_arr [OUT_DIM];

  for (genvar r = 0; r < ROWS; r++) begin : g_x_row
    for (genvar k = 0; k < IN_DIM; k++) begin : g_x_col
      assign x_arr[r][k] = x_in_i[(r*IN_DIM+k)*DATA_W +: DATA_W];
    end
  end
  for (genvar k = 0; k < IN_DIM; k++) begin : g_w_row
    for (genvar o = 0; o < OUT_DIM; o++) begin : g_w_col
      assign w_arr[k][o] = w_in_i[(k*OUT_DIM+o)*DATA_W +: DATA_W];
    end
  end
  for (genvar o = 0; o < OUT_DIM; o++) begin : g_b
    assign b_arr[o] = bias_in_i[o*DATA_W +: DATA_W];
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [4:0]       shift_q, shift_d;
  logic             relu_q, relu_d;
  logic             clear_acc;
  logic             last_grp;
  logic [DATA_W-1:0] x_op;

  assign last_grp = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign x_op     = x_arr[row_q][k_q];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    row_d     = row_q;
    col_d     = col_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    clear_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shift_d = cfg_shift_i;
          relu_d  = cfg_relu_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        row_d     = '0;
        col_d     = '0;
        k_d       = '0;
        clear_acc = 1'b1;
        state_d   = ST_MAC;
      end
      ST_MAC: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        k_d     = '0;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        // Results and indices stay frozen until the sink takes them.
        if (out_ready_i) begin
          if (last_grp) begin
            state_d = ST_DONE;
          end else begin
            clear_acc = 1'b1;
            k_d       = '0;
            state_d   = ST_MAC;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + COL_STEP;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [COL_W-1:0] col_l;
    assign col_l = col_q + COL_W'(l);

    linear_stream_engine_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (clear_acc),
      .mac_en_i (state_q == ST_MAC),
      .fin_en_i (state_q == ST_FIN),
      .x_i      (x_op),
      .w_i      (w_arr[k_q][col_l]),
      .bias_i   (b_arr[col_l]),
      .shift_i  (shift_q),
      .relu_i   (relu_q),
      .y_o      (out_data_o[l*DATA_W +: DATA_W])
    );
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign out_valid_o = (state_q == ST_OUT);
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;

endmodule
`default_nettype wire

// File: tb/tb_linear_stream_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_linear_stream_engine - directed jobs against hand-computed outputs. Rev 1.0
// ----------------------------------------------------------------------------
module tb_linear_stream_engine;

  localparam int ROWS    = 16;
  localparam int IN_DIM  = 16;
  localparam int OUT_DIM = 16;
  localparam int DATA_W  = 8;
  localparam int LANES   = 4;
  localparam int GPR     = OUT_DIM / LANES;
  localparam int GROUPS  = ROWS * GPR;
  localparam int JOB_CYC = 1 + GROUPS * (IN_DIM + 2) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [4:0] cfg_shift = '0;
  logic cfg_relu = 1'b0;
  logic [ROWS*IN_DIM*DATA_W-1:0]    x_in = '0;
  logic [IN_DIM*OUT_DIM*DATA_W-1:0] w_in = '0;
  logic [OUT_DIM*DATA_W-1:0]        bias_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [LANES*DATA_W-1:0] out_data;
  logic [3:0] out_row, out_col;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  linear_stream_engine #(
    .ROWS(ROWS), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W), .LANES(LANES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .cfg_shift_i (cfg_shift),
    .cfg_relu_i  (cfg_relu),
    .x_in_i      (x_in),
    .w_in_i      (w_in),
    .bias_in_i   (bias_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_row_o   (out_row),
    .out_col_o   (out_col)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hand-derived results for each directed data set.
  function automatic int exp_y(input int t, input int r, input int o);
    case (t)
      1:       return r + o - 8;         // identity W: Y = X
      2:       return 127;               // 127*127*16 saturates
      3:       return 1;                 // (258064 + 2^17) >> 18
      4:       return 0;                 // -16 + 5 = -11, ReLU
      5:       return -11;
      6:       return (o % 2 == 0) ? 2 : -1;  // (6+2)>>2, (-6+2)>>>2
      default: return 0;
    endcase
  endfunction

  task automatic set_data(input int t);
    int xv, wv, bv;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < IN_DIM; k++) begin
        case (t)
          1:       xv = r + k - 8;
          2, 3:    xv = 127;
          4, 5:    xv = -1;
          default: xv = 0;
        endcase
        x_in[(r*IN_DIM+k)*DATA_W +: DATA_W] = 8'(xv);
      end
    for (int k = 0; k < IN_DIM; k++)
      for (int o = 0; o < OUT_DIM; o++) begin
        case (t)
          1:       wv = (k == o) ? 1 : 0;
          2, 3:    wv = 127;
          4, 5:    wv = 1;
          default: wv = 3;
        endcase
        w_in[(k*OUT_DIM+o)*DATA_W +: DATA_W] = 8'(wv);
      end
    for (int o = 0; o < OUT_DIM; o++) begin
      case (t)
        4, 5:    bv = 5;
        6:       bv = (o % 2 == 0) ? 6 : -6;
        default: bv = 0;
      endcase
      bias_in[o*DATA_W +: DATA_W] = 8'(bv);
    end
    cfg_shift = (t == 3) ? 5'd18 : (t == 6) ? 5'd2 : 5'd0;
    cfg_relu  = (t == 4);
  endtask

  function automatic logic signed [31:0] lane(input logic [LANES*DATA_W-1:0] d, input int l);
    logic [DATA_W-1:0] s;
    s = d[l*DATA_W +: DATA_W];
    return 32'($signed(s));
  endfunction

  // mode 0: sink always ready; mode 1: random ready plus a 20-cycle stall.
  task automatic run_job(input int t, input int mode, input bit poke);
    int c, g, col;
    bit fin, stall_prev;
    logic [LANES*DATA_W-1:0] held_data;
    logic [3:0] held_row, held_col;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 1; g = 0; fin = 0; stall_prev = 0;
    held_data = '0; held_row = '0; held_col = '0;
    check($sformatf("t%0d busy after start", t), 32'(busy), 1);
    check($sformatf("t%0d valid in load", t), 32'(out_valid), 0);
    while (!fin && c < 4000) begin
      @(posedge clk); #1;
      c++;
      if (poke) start = (c == 100);
      if (mode == 0) out_ready = 1'b1;
      else out_ready = (c >= 300 && c < 320) ? 1'b0 : 1'($urandom_range(0, 1));
      if (stall_prev) begin
        check($sformatf("t%0d hold valid c%0d", t, c), 32'(out_valid), 1);
        check($sformatf("t%0d hold data c%0d", t, c), 32'(out_data), 32'(held_data));
        check($sformatf("t%0d hold row c%0d", t, c), 32'(out_row), 32'(held_row));
        check($sformatf("t%0d hold col c%0d", t, c), 32'(out_col), 32'(held_col));
      end
      if (out_valid && out_ready) begin
        col = (g % GPR) * LANES;
        check($sformatf("t%0d row g%0d", t, g), 32'(out_row), g / GPR);
        check($sformatf("t%0d col g%0d", t, g), 32'(out_col), col);
        for (int l = 0; l < LANES; l++)
          check($sformatf("t%0d y r%0d c%0d l%0d", t, g / GPR, col, l),
                lane(out_data, l), exp_y(t, g / GPR, col + l));
        g++;
      end
      stall_prev = out_valid && !out_ready;
      held_data = out_data; held_row = out_row; held_col = out_col;
      if (done) begin
        fin = 1;
        check($sformatf("t%0d groups", t), g, GROUPS);
        check($sformatf("t%0d busy at done", t), 32'(busy), 1);
        check($sformatf("t%0d valid at done", t), 32'(out_valid), 0);
        if (mode == 0) check($sformatf("t%0d job cycles", t), c, JOB_CYC);
      end
    end
    check($sformatf("t%0d finished in budget", t), 32'(fin), 1);
    if (poke) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check($sformatf("t%0d done one pulse", t), 32'(done), 0);
    check($sformatf("t%0d idle after done", t), 32'(busy), 0);
    @(posedge clk); #1;
    check($sformatf("t%0d start in done ignored", t), 32'(busy), 0);
  endtask

  initial begin
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst valid", 32'(out_valid), 0);
    check("rst data", 32'(out_data), 0);
    check("rst row", 32'(out_row), 0);
    check("rst col", 32'(out_col), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int t = 1; t <= 6; t++) begin
      set_data(t);
      run_job(t, 0, 1'b0);
    end

    set_data(1);
    run_job(1, 1, 1'b0);

    // Abort at k=7 of group row 3 / col 8 (MAC entry at cycle 2+18*14).
    @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (260) @(posedge clk);
    #1;
    check("abort pre row", 32'(out_row), 3);
    check("abort pre col", 32'(out_col), 8);
    check("abort pre busy", 32'(busy), 1);
    check("abort pre y", lane(out_data, 0), -1);
    #2 reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort valid", 32'(out_valid), 0);
    check("abort data", 32'(out_data), 0);
    check("abort row", 32'(out_row), 0);
    check("abort col", 32'(out_col), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort no done", 32'(done), 0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort stays idle", 32'(busy), 0);

    run_job(1, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
